// File: rtl/instr_mem_pkg.sv
// Shared types for the pipelined instruction memory.
// Fault codes and the per-stage bundle carried down the read pipeline.
package instr_mem_pkg;

  localparam int WORD_SIZE_POW = 2;
  localparam int MAX_ADDR_WIDTH = 64;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_RANGE    = 2'b10
  } fault_e;

  typedef struct packed {
    logic                      valid;
    logic [MAX_ADDR_WIDTH-1:0] addr;
    fault_e                    fault;
  } stage_t;

endpackage

// File: rtl/instr_mem_array.sv
// Byte-lane instruction RAM: one sync-read port, one byte-enabled write port.
// Kept standalone so a vendor macro can replace it.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int DEPTH_POW = 10
) (
  input  logic                 clk,
  input  logic                 re,
  input  logic [DEPTH_POW-1:0] raddr,
  output logic [31:0]          rdata,
  input  logic                 we,
  input  logic [DEPTH_POW-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           be
);

  localparam int DEPTH = 1 << DEPTH_POW;
  localparam int LANES = 1 << WORD_SIZE_POW;

  logic [LANES-1:0][7:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < LANES; b++) begin
        if (be[b]) begin
          ram[waddr][b] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= ram[raddr];
    end
  end

endmodule

// File: rtl/instr_mem_pipelined.sv
// Synchronous instruction memory with a stallable, flushable read pipeline.
// Faulted fetches skip the array and return zero data.
module instr_mem_pipelined
  import instr_mem_pkg::*;
#(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DEPTH_POW = 10,
  parameter int READ_LATENCY  = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [ADDR_WIDTH-1:0]    req_addr_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DATA_WIDTH-1:0]    rsp_data_o,
  output logic [ADDR_WIDTH-1:0]    rsp_addr_o,
  output logic [1:0]               rsp_fault_o,
  input  logic                     flush_i,
  input  logic                     ld_en_i,
  input  logic [MEM_DEPTH_POW-1:0] ld_addr_i,
  input  logic [DATA_WIDTH-1:0]    ld_data_i,
  input  logic [3:0]               ld_be_i
);

  localparam int IDX_LO = WORD_SIZE_POW;
  localparam int IDX_HI = MEM_DEPTH_POW + WORD_SIZE_POW - 1;

  logic                  adv;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] off;
  logic                  below;
  logic                  above;
  fault_e                req_fault;
  stage_t                req_st;
  stage_t                st [READ_LATENCY];
  stage_t                last;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] last_data;

  assign adv         = !rsp_valid_o || rsp_ready_i;
  assign req_ready_o = adv && !ld_en_i && !flush_i;
  assign accept      = req_valid_i && req_ready_o;

  // BASE_ADDR is word aligned, so off[1:0] equals the request's low bits
  assign off   = req_addr_i - BASE_ADDR;
  assign below = req_addr_i < BASE_ADDR;
  assign above = |(off >> (MEM_DEPTH_POW + WORD_SIZE_POW));

  always_comb begin
    req_fault = FLT_NONE;
    priority case (1'b1)
      (off[1:0] != 2'b00): req_fault = FLT_MISALIGN;
      (below || above):    req_fault = FLT_RANGE;
      default:             req_fault = FLT_NONE;
    endcase
  end

  always_comb begin
    req_st = '0;
    if (accept) begin
      req_st.valid = 1'b1;
      req_st.addr  = MAX_ADDR_WIDTH'(req_addr_i);
      req_st.fault = req_fault;
    end
  end

  instr_mem_array #(
    .DEPTH_POW (MEM_DEPTH_POW)
  ) u_array (
    .clk   (clk),
    .re    (accept && (req_fault == FLT_NONE)),
    .raddr (off[IDX_HI:IDX_LO]),
    .rdata (rdata),
    .we    (ld_en_i),
    .waddr (ld_addr_i),
    .wdata (ld_data_i),
    .be    (ld_be_i)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        st[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        st[i].valid <= 1'b0;
      end
    end else if (adv) begin
      st[0] <= req_st;
      for (int i = 1; i < READ_LATENCY; i++) begin
        st[i] <= st[i-1];
      end
    end
  end

  // Array output is stage 1 data; later stages carry it forward
  if (READ_LATENCY == 1) begin : g_l1
    assign last_data = rdata;
  end else begin : g_ln
    logic [DATA_WIDTH-1:0] dreg [READ_LATENCY-1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
          dreg[i] <= '0;
        end
      end else if (adv) begin
        dreg[0] <= rdata;
        for (int i = 1; i < READ_LATENCY - 1; i++) begin
          dreg[i] <= dreg[i-1];
        end
      end
    end

    assign last_data = dreg[READ_LATENCY-2];
  end

  assign last        = st[READ_LATENCY-1];
  assign rsp_valid_o = last.valid;
  assign rsp_addr_o  = last.addr[ADDR_WIDTH-1:0];
  assign rsp_fault_o = last.fault;
  assign rsp_data_o  = (last.valid && last.fault == FLT_NONE)
                       ? last_data : '0;

endmodule

// File: tb/tb_instr_mem_pipelined.sv
// Scoreboard bench for instr_mem_pipelined at READ_LATENCY 1, 2 and 3.
// Inputs are broadcast; the selected instance is observed and checked.
module tb_instr_mem_pipelined;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        rsp_ready;
  logic        flush;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic [3:0]  ld_be;

  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_data  [3];
  logic [63:0] rsp_addr  [3];
  logic [1:0]  rsp_fault [3];

  int sel = 0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit lat_chk = 1'b0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    logic [1:0]  fault;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb [$];
  logic [31:0] mdl [1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    instr_mem_pipelined #(
      .READ_LATENCY (g + 1)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready[g]),
      .req_addr_i  (req_addr),
      .rsp_valid_o (rsp_valid[g]),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data[g]),
      .rsp_addr_o  (rsp_addr[g]),
      .rsp_fault_o (rsp_fault[g]),
      .flush_i     (flush),
      .ld_en_i     (ld_en),
      .ld_addr_i   (ld_addr),
      .ld_data_i   (ld_data),
      .ld_be_i     (ld_be)
    );
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s rl=%0d got=%h want=%h", tag, sel + 1, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [63:0] a, input int c);
    exp_t e;
    e.addr = a;
    e.acc  = c;
    e.lat  = lat_chk;
    if (a[1:0] != 2'b00) e.fault = 2'b01;
    else if (a >= 64'h1000) e.fault = 2'b10;
    else e.fault = 2'b00;
    e.data = (e.fault == 2'b00) ? mdl[a[11:2]] : 32'h0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en && rsp_valid[sel] && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("stray_rsp", {63'b0, rsp_valid[sel]}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_addr", rsp_addr[sel], e.addr);
        chk("rsp_data", {32'b0, rsp_data[sel]}, {32'b0, e.data});
        chk("rsp_fault", {62'b0, rsp_fault[sel]}, {62'b0, e.fault});
        if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(sel + 1));
      end
    end
  end

  task automatic send(input logic [63:0] a, output int waits);
    int c;
    waits = 0;
    req_valid = 1'b1;
    req_addr  = a;
    forever begin
      #1;
      if (req_ready[sel]) begin
        c = cyc;
        tick();
        sb.push_back(mk(a, c));
        break;
      end
      if (waits >= 60) begin
        chk("accept_to", {63'b0, req_ready[sel]}, 64'd1);
        break;
      end
      tick();
      waits++;
    end
    req_valid = 1'b0;
  endtask

  task automatic load(input int idx, input logic [31:0] d,
                      input logic [3:0] be);
    ld_en   = 1'b1;
    ld_addr = 10'(idx);
    ld_data = d;
    ld_be   = be;
    #1;
    chk("ld_block", {63'b0, req_ready[sel]}, 64'd0);
    tick();
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    end
    ld_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {63'b0, rsp_valid[sel]}, 64'd0);
    chk({tag, "_data"}, {32'b0, rsp_data[sel]}, 64'd0);
    chk({tag, "_addr"}, rsp_addr[sel], 64'd0);
    chk({tag, "_fault"}, {62'b0, rsp_fault[sel]}, 64'd0);
  endtask

  task automatic fill(input logic [63:0] a0);
    int w;
    rsp_ready = 1'b0;
    lat_chk = 1'b0;
    for (int k = 0; k <= sel; k++) send(a0 + 64'(4 * k), w);
    chk("fill_held", {63'b0, rsp_valid[sel]}, 64'd1);
  endtask

  task automatic run_one();
    int w;
    logic [31:0] d0;
    logic [63:0] a0;

    mon_en = 1'b0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    rsp_ready = 1'b1;
    flush = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    ld_be = '0;
    repeat (2) tick();
    sb.delete();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    load(0, 32'h13, 4'hF);
    load(1, 32'h93, 4'hF);
    load(2, 32'h113, 4'hF);
    load(3, 32'h193, 4'hF);
    load(1023, 32'h0000_006F, 4'hF);

    lat_chk = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(64'(4 * k), w);
      chk("b2b_wait", 64'(w), 64'd0);
    end
    drain();

    send(64'h6, w);
    send(64'h1000, w);
    send(64'hFFC, w);
    send(64'h1002, w);
    send(64'hFFFF_FFFF_FFFF_FFF0, w);
    drain();

    lat_chk = 1'b0;
    rsp_ready = 1'b0;
    fork
      begin
        int w2;
        send(64'h8, w2);
        send(64'hC, w2);
      end
      begin
        int n = 0;
        while (!rsp_valid[sel] && n < 20) begin
          tick();
          n++;
        end
        chk("stall_seen", {63'b0, rsp_valid[sel]}, 64'd1);
        d0 = rsp_data[sel];
        a0 = rsp_addr[sel];
        repeat (5) begin
          tick();
          chk("stall_data", {32'b0, rsp_data[sel]}, {32'b0, d0});
          chk("stall_addr", rsp_addr[sel], a0);
          chk("stall_rdy", {63'b0, req_ready[sel]}, 64'd0);
        end
        rsp_ready = 1'b1;
      end
    join
    drain();

    fill(64'h0);
    flush = 1'b1;
    req_valid = 1'b1;
    req_addr = 64'h8;
    #1;
    chk("flush_rdy", {63'b0, req_ready[sel]}, 64'd0);
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    sb.delete();
    chk("flush_valid", {63'b0, rsp_valid[sel]}, 64'd0);
    rsp_ready = 1'b1;
    repeat (5) tick();
    lat_chk = 1'b1;
    send(64'hC, w);
    drain();

    load(5, 32'hDEAD_BEEF, 4'hF);
    load(5, 32'h0000_AA00, 4'b0010);
    chk("ld_model", {32'b0, mdl[5]}, 64'hDEAD_AAEF);
    send(64'h14, w);
    drain();

    fill(64'h4);
    rst_n = 1'b0;
    tick();
    sb.delete();
    chk_zero("midrst");
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    lat_chk = 1'b1;
    tick();
    send(64'h8, w);
    drain();
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      sel = s;
      run_one();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
